// File: rtl/matrix_pkg.sv
// matrix_pkg: opcode and module-select constants shared across the matrix
// engine, plus the fetch FSM state type and the opcode classification helper.
package matrix_pkg;

  // Instruction opcodes
  localparam logic [7:0] OpAdd       = 8'h00;
  localparam logic [7:0] OpSub       = 8'h01;
  localparam logic [7:0] OpTranspose = 8'h02;
  localparam logic [7:0] OpScale     = 8'h03;
  localparam logic [7:0] OpMultiply  = 8'h04;
  localparam logic [7:0] OpStop      = 8'h05;

  // Module-enable codes carried in addressBus[15:12]
  localparam logic [3:0] ModInstruction = 4'h0;
  localparam logic [3:0] ModMemory      = 4'h1;
  localparam logic [3:0] ModAlu         = 4'h2;
  localparam logic [3:0] ModExe         = 4'h3;
  localparam logic [3:0] ModRegister    = 4'h4;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StPresent,
    StHalt
  } fetchStateT;

  // Anything past the stop opcode has no defined meaning.
  function automatic logic isIllegalOp(input logic [7:0] op);
    return op > OpStop;
  endfunction

endpackage

// File: rtl/inst_field_decode.sv
// inst_field_decode: combinational split of a 32-bit instruction word into its
// byte fields, with stop / illegal opcode flags.
module inst_field_decode
  import matrix_pkg::*;
(
  input  logic [31:0] instWord,
  output logic [7:0]  opcode,
  output logic [7:0]  dest,
  output logic [7:0]  src1,
  output logic [7:0]  src2,
  output logic        is_stop,
  output logic        is_illegal
);

  // Field split and opcode classification
  always_comb begin
    opcode     = instWord[31:24];
    dest       = instWord[23:16];
    src1       = instWord[15:8];
    src2       = instWord[7:0];
    is_stop    = (instWord[31:24] == OpStop);
    is_illegal = isIllegalOp(instWord[31:24]);
  end

endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: fetches instruction words from the instruction ROM one at a
// time, decodes them and hands them to the execute stage over a valid/ready
// handshake. A stop opcode or running off the end of the program halts the
// unit until reset.
// Optional: define FETCH_ILLEGAL_TRAP_EN to halt with error on opcodes above
// the stop opcode instead of presenting them.
module fetch_decode
  import matrix_pkg::*;
#(
  parameter int unsigned PROG_LEN = 6,
  parameter int unsigned PC_W     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [15:0]     addressBus,
  output logic            readFromInst,
  input  logic [31:0]     instructionData,
  output logic [7:0]      opcode,
  output logic [7:0]      dest,
  output logic [7:0]      src1,
  output logic [7:0]      src2,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic            halted,
  output logic            error,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] LastPc = PC_W'(PROG_LEN - 1);

  fetchStateT      stateQ, stateD;
  logic [PC_W-1:0] pcQ, pcD;
  logic [31:0]     instQ, instD;
  logic            errorQ, errorD;

  logic            handshake;
  logic            atLastPc;
  logic            trap;
  logic [3:0]      pcIdx;

  // The ROM word on the bus is classified during WAIT so the branch to HALT
  // needs no extra cycle; only its flags are of interest.
  logic            busStop, busIllegal;
  logic [7:0]      unusedBusOpcode, unusedBusDest, unusedBusSrc1, unusedBusSrc2;
  logic            unusedRegStop, unusedRegIllegal;

  inst_field_decode u_bus_decode (
    .instWord   (instructionData),
    .opcode     (unusedBusOpcode),
    .dest       (unusedBusDest),
    .src1       (unusedBusSrc1),
    .src2       (unusedBusSrc2),
    .is_stop    (busStop),
    .is_illegal (busIllegal)
  );

  // Decoded outputs always mirror the instruction register.
  inst_field_decode u_reg_decode (
    .instWord   (instQ),
    .opcode     (opcode),
    .dest       (dest),
    .src1       (src1),
    .src2       (src2),
    .is_stop    (unusedRegStop),
    .is_illegal (unusedRegIllegal)
  );

`ifdef FETCH_ILLEGAL_TRAP_EN
  assign trap = busIllegal;
`else
  logic unusedBusIllegal;
  assign unusedBusIllegal = busIllegal;
  assign trap = 1'b0;
`endif

  assign handshake = (stateQ == StPresent) && inst_ready;
  assign atLastPc  = (pcQ == LastPc);
  assign pcIdx     = 4'(pcQ);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:    if (start) stateD = StIssue;
      StIssue:   stateD = StWait;
      StWait:    stateD = (busStop || trap) ? StHalt : StPresent;
      StPresent: if (inst_ready) stateD = atLastPc ? StHalt : StIssue;
      StHalt:    stateD = StHalt;
      default:   stateD = StIdle;
    endcase
  end

  // Bus, handshake and status outputs decoded from the current state
  always_comb begin
    readFromInst = 1'b0;
    addressBus   = 16'h0000;
    inst_valid   = 1'b0;
    halted       = 1'b0;
    unique case (stateQ)
      StIssue: begin
        readFromInst = 1'b1;
        addressBus   = {ModInstruction, pcIdx, 8'h00};
      end
      StPresent: inst_valid = 1'b1;
      StHalt:    halted = 1'b1;
      default:   ;
    endcase
  end

  // Datapath next-state: capture in WAIT, advance pc on handshake, sticky error
  always_comb begin
    pcD    = pcQ;
    instD  = instQ;
    errorD = errorQ;
    if (stateQ == StWait) begin
      instD = instructionData;
      if (trap) errorD = 1'b1;
    end
    if (handshake) begin
      // Last ROM word consumed without a stop: halt rather than wrap.
      if (atLastPc) errorD = 1'b1;
      else          pcD = pcQ + PC_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcQ    <= '0;
      instQ  <= '0;
      errorQ <= 1'b0;
    end else begin
      pcQ    <= pcD;
      instQ  <= instD;
      errorQ <= errorD;
    end
  end

  assign error = errorQ;
  assign pc    = pcQ;

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: randomized scoreboard bench. A program-level model walks the
// ROM and queues the expected fetch addresses and presented instructions; an
// independent monitor pops and compares whenever the DUT fetches or hands off.
module tb_fetch_decode;

  localparam int PROG_LEN = 6;
  localparam int PC_W     = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [15:0]     addressBus;
  logic            readFromInst;
  logic [31:0]     instructionData;
  logic [7:0]      opcode, dest, src1, src2;
  logic            inst_valid;
  logic            inst_ready;
  logic            halted;
  logic            error;
  logic [PC_W-1:0] pc;

  fetch_decode #(
    .PROG_LEN (PROG_LEN),
    .PC_W     (PC_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .addressBus      (addressBus),
    .readFromInst    (readFromInst),
    .instructionData (instructionData),
    .opcode          (opcode),
    .dest            (dest),
    .src1            (src1),
    .src2            (src2),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .halted          (halted),
    .error           (error),
    .pc              (pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM: a read strobe at one edge makes the addressed word valid for the
  // following cycle only; the bus floats otherwise.
  logic [31:0] rom [16];
  logic        romDrive = 1'b0;
  logic [3:0]  romIdx   = 4'h0;
  always @(posedge clk) begin
    romDrive <= readFromInst;
    romIdx   <= addressBus[11:8];
  end
  assign instructionData = romDrive ? rom[romIdx] : 32'hzzzz_zzzz;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0]     word;
    logic [PC_W-1:0] pc;
  } presT;

  presT        expPres[$];
  logic [15:0] expAddr[$];

  // Program-level reference: walk the ROM as the execute stage would see it.
  task automatic modelProgram(output bit expErr, output logic [PC_W-1:0] expPc);
    int p = 0;
    logic [31:0] w;
    expErr = 1'b0;
    while (1) begin
      expAddr.push_back({4'h0, 4'(p), 8'h00});
      w = rom[p];
      if (w[31:24] == 8'h05) break;
`ifdef FETCH_ILLEGAL_TRAP_EN
      if (w[31:24] > 8'h05) begin
        expErr = 1'b1;
        break;
      end
`endif
      expPres.push_back('{word: w, pc: PC_W'(p)});
      if (p == PROG_LEN - 1) begin
        expErr = 1'b1;
        break;
      end
      p++;
    end
    expPc = PC_W'(p);
  endtask

  // Monitor state
  bit          monEn     = 1'b0;
  bit          fullRate  = 1'b0;
  bit          prevRead  = 1'b0;
  bit          prevValid = 1'b0;
  bit          prevReady = 1'b0;
  logic [35:0] heldWord  = '0;
  int          lastHs    = -1;
  presT        monE;

  always @(negedge clk) begin
    if (monEn) begin
      if (readFromInst) begin
        check("read_one_cycle", 64'(prevRead), 64'd0);
        check("fetch_expected", 64'(expAddr.size() != 0), 64'd1);
        if (expAddr.size() != 0) check("fetch_address", 64'(addressBus), 64'(expAddr.pop_front()));
      end else begin
        check("bus_idle_zero", 64'(addressBus), 64'd0);
      end
      if (prevValid && !prevReady) begin
        check("hold_valid", 64'(inst_valid), 64'd1);
        check("hold_fields", 64'({opcode, dest, src1, src2, pc}), 64'(heldWord));
      end
      if (inst_valid && inst_ready) begin
        check("present_expected", 64'(expPres.size() != 0), 64'd1);
        if (expPres.size() != 0) begin
          monE = expPres.pop_front();
          check("present_fields", 64'({opcode, dest, src1, src2}), 64'(monE.word));
          check("present_pc", 64'(pc), 64'(monE.pc));
        end
        if (fullRate && lastHs >= 0) check("issue_spacing", 64'(cyc - lastHs), 64'd3);
        lastHs = cyc;
      end
      prevRead  = readFromInst;
      prevValid = inst_valid;
      prevReady = inst_ready;
      heldWord  = {opcode, dest, src1, src2, pc};
    end
  end

  task automatic doReset();
    reset      = 1'b0;
    start      = 1'b0;
    inst_ready = 1'b0;
    #1;
    check("reset_state", 64'({addressBus, readFromInst, inst_valid, halted, error, pc,
                              opcode, dest, src1, src2}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic pulseStart();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic loadDefault();
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    for (int i = 0; i < 5; i++) rom[i] = {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
    rom[5] = 32'h05_00_00_00;
  endtask

  task automatic loadNoStop();
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    for (int i = 0; i < PROG_LEN; i++) rom[i] = {8'(i % 5), 8'($urandom), 8'($urandom), 8'($urandom)};
  endtask

  task automatic loadRandom();
    int r;
    logic [7:0] op;
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    for (int i = 0; i < PROG_LEN; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      op = 8'($urandom_range(0, 4));
      else if (r < 8) op = 8'h05;
      else            op = 8'($urandom_range(6, 255));
      rom[i] = {op, 8'($urandom), 8'($urandom), 8'($urandom)};
    end
  endtask

  // mode 0: ready held high; 1: random ready and stray start pulses;
  // 2: ready held low for the first 4 presented cycles, then high.
  task automatic runProgram(input int mode, input bit doRst);
    bit              expErr;
    logic [PC_W-1:0] expPc;
    int              budget;
    int              stall;
    expPres.delete();
    expAddr.delete();
    modelProgram(expErr, expPc);
    if (doRst) doReset();
    inst_ready = (mode == 0);
    prevRead   = 1'b0;
    prevValid  = 1'b0;
    lastHs     = -1;
    fullRate   = (mode == 0);
    monEn      = 1'b1;
    pulseStart();
    budget = 0;
    stall  = 0;
    while (!halted && budget < 300) begin
      @(posedge clk);
      #1;
      if (mode == 1) begin
        inst_ready = 1'($urandom_range(0, 1));
        start      = ($urandom_range(0, 7) == 0);
      end else if (mode == 2) begin
        if (stall >= 4) begin
          inst_ready = 1'b1;
        end else begin
          inst_ready = 1'b0;
          if (inst_valid) begin
            stall++;
            check("stall_fields", 64'({opcode, dest, src1, src2}), 64'h0002_0001);
            check("stall_pc", 64'(pc), 64'd0);
          end
        end
      end
      budget++;
    end
    start = 1'b0;
    check("halt_within_budget", 64'(budget < 300), 64'd1);
    @(negedge clk);
    check("halted", 64'(halted), 64'd1);
    check("error", 64'(error), 64'(expErr));
    check("final_pc", 64'(pc), 64'(expPc));
    check("valid_after_halt", 64'(inst_valid), 64'd0);
    check("pres_queue_drained", 64'(expPres.size()), 64'd0);
    check("addr_queue_drained", 64'(expAddr.size()), 64'd0);
    // HALT ignores start; status stays put.
    pulseStart();
    repeat (3) @(posedge clk);
    #1;
    check("halt_sticky", 64'({halted, error, pc, inst_valid, readFromInst}),
          64'({1'b1, expErr, expPc, 1'b0, 1'b0}));
    monEn = 1'b0;
  endtask

  // Reset asserted in the WAIT of pc 2 must clear everything at once and
  // leave the unit idle until a new start.
  task automatic resetMidWait();
    int budget = 0;
    bit seen   = 1'b0;
    loadDefault();
    doReset();
    inst_ready = 1'b1;
    monEn      = 1'b0;
    pulseStart();
    while (!seen && budget < 50) begin
      @(negedge clk);
      if (readFromInst && addressBus == 16'h0200) seen = 1'b1;
      budget++;
    end
    check("reach_pc2_issue", 64'(seen), 64'd1);
    @(posedge clk);
    #2;
    check("pc_before_reset", 64'(pc), 64'd2);
    reset = 1'b0;
    #1;
    check("reset_async_outputs", 64'({addressBus, readFromInst, inst_valid, halted, error, pc,
                                      opcode, dest, src1, src2}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_fetch_without_start", 64'({addressBus, readFromInst, inst_valid}), 64'd0);
    end
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    inst_ready = 1'b0;

    loadDefault();
    runProgram(0, 1'b1);

    loadDefault();
    rom[0] = 32'h00_02_00_01;
    runProgram(2, 1'b1);

    resetMidWait();
    runProgram(0, 1'b0);

    loadDefault();
    rom[1] = 32'h07_01_01_01;
    runProgram(1, 1'b1);

    loadNoStop();
    runProgram(0, 1'b1);

    repeat (20) begin
      loadRandom();
      runProgram(1, 1'b1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
